// File: rtl/ahb_pkg.sv
// Shared AHB types: transfer/size/burst encodings and the slave FSM states.
package ahb_pkg;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic {
    HBURST_SINGLE = 1'b0,
    HBURST_INCR   = 1'b1
  } hburst_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  // Byte-lane enable for a transfer at byte offset ofs.
  function automatic logic [3:0] lane_be(input logic is_byte, input logic [1:0] ofs);
    return is_byte ? (4'b0001 << ofs) : 4'b1111;
  endfunction
endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB bus bundle between one master and the memory slave.
interface ahb_slave_mem_if;
  import ahb_pkg::*;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  htrans_e     HTRANS;
  hburst_e     HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HWDATA,
                  input  HRDATA, HREADY, HRESP);
  modport slave  (input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HWDATA,
                  output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/ahb_byte_ram.sv
// DEPTH x 8 storage organised as four byte lanes; one byte-enabled write
// port, one asynchronous 4-byte read port. Contents are never reset.
module ahb_byte_ram #(
  parameter int DEPTH = 256,
  parameter int WA    = 6
) (
  input  logic          clk_i,
  input  logic [3:0]    we_i,
  input  logic [WA-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [WA-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH/4];
    // lane write, no reset
    always_ff @(posedge clk_i)
      if (we_i[l]) mem[waddr_i] <= wdata_i[8*l +: 8];
    assign rdata_o[8*l +: 8] = mem[raddr_i];
  end
endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave with programmable data-phase wait states.
// Optional `SLAVE_ERR_EN: out-of-range, misaligned-word and unsupported-size
// transfers get a two-cycle ERROR response instead of wrapping/aligning.
module ahb_slave_mem import ahb_pkg::*; #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input logic           HCLK,
  input logic           HRESTn,
  ahb_slave_mem_if.slave bus
);
  localparam int BA = $clog2(DEPTH);
  localparam int WA = (BA > 2) ? BA - 2 : 1;

  slv_state_e    state_q;
  logic [3:0]    wcnt_q;
  logic [BA-1:0] addr_q;
  logic          wr_q, byte_q;
  logic          hready_q, hresp_q;
  logic [31:0]   hrdata_q;

  function automatic logic [WA-1:0] widx(input logic [BA-1:0] a);
    return WA'(a >> 2);
  endfunction

  logic          accept, err_in, in_byte;
  logic [BA-1:0] in_addr;
  assign accept  = hready_q & bus.HSEL & bus.HTRANS[1];
  assign in_addr = bus.HADDR[BA-1:0];
  assign in_byte = (bus.HSIZE == HSIZE_BYTE);   // anything else acts as a word

`ifdef SLAVE_ERR_EN
  assign err_in = (bus.HADDR >= 32'(DEPTH)) |
                  ((bus.HSIZE == HSIZE_WORD) && (bus.HADDR[1:0] != 2'b00)) |
                  ((bus.HSIZE != HSIZE_BYTE) && (bus.HSIZE != HSIZE_WORD));
`else
  assign err_in = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.HBURST, bus.HADDR};

  // Write completes on the DONE cycle; HWDATA is valid then.
  logic        wr_pend;
  logic [3:0]  wbe;
  logic [31:0] wdata;
  assign wr_pend = (state_q == ST_DONE) & wr_q;
  assign wbe     = lane_be(byte_q, addr_q[1:0]);
  assign wdata   = byte_q ? {4{bus.HWDATA[7:0]}} : bus.HWDATA;

  // With no wait states the read is captured straight from the address
  // phase; otherwise from the registered address at the end of WAIT.
  logic [BA-1:0] rd_addr;
  logic          rd_byte;
  logic [31:0]   ram_rdata, rd_merged, rd_val;
  assign rd_addr = (WAIT_STATES == 0) ? in_addr : addr_q;
  assign rd_byte = (WAIT_STATES == 0) ? in_byte : byte_q;

  ahb_byte_ram #(.DEPTH(DEPTH), .WA(WA)) u_ram (
    .clk_i   (HCLK),
    .we_i    (wr_pend ? wbe : 4'b0000),
    .waddr_i (widx(addr_q)),
    .wdata_i (wdata),
    .raddr_i (widx(rd_addr)),
    .rdata_o (ram_rdata)
  );

  // Forward a write completing this cycle into a read captured this cycle.
  always_comb begin
    rd_merged = ram_rdata;
    for (int l = 0; l < 4; l++)
      if (wr_pend && (widx(addr_q) == widx(rd_addr)) && wbe[l])
        rd_merged[8*l +: 8] = wdata[8*l +: 8];
  end
  assign rd_val = rd_byte ? {24'h0, rd_merged[{rd_addr[1:0], 3'b000} +: 8]} : rd_merged;

  // Transfer FSM with registered HREADY/HRESP/HRDATA.
  always_ff @(posedge HCLK or negedge HRESTn) begin
    if (!HRESTn) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      byte_q   <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      hrdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_WAIT: begin
          if (wcnt_q == 4'd0) begin
            state_q  <= ST_DONE;
            hready_q <= 1'b1;
            if (!wr_q) hrdata_q <= rd_val;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        ST_ERR1: begin
          state_q  <= ST_ERR2;
          hready_q <= 1'b1;
        end
        default: begin  // IDLE, DONE, ERR2: bus may present a new address
          state_q  <= ST_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
          if (accept) begin
            addr_q <= in_addr;
            wr_q   <= bus.HWRITE;
            byte_q <= in_byte;
            if (err_in) begin
              state_q  <= ST_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
              wr_q     <= 1'b0;
            end else if (WAIT_STATES == 0) begin
              state_q <= ST_DONE;
              if (!bus.HWRITE) hrdata_q <= rd_val;
            end else begin
              state_q  <= ST_WAIT;
              hready_q <= 1'b0;
              wcnt_q   <= 4'(WAIT_STATES - 1);
            end
          end
        end
      endcase
    end
  end

  assign bus.HREADY = hready_q;
  assign bus.HRESP  = hresp_q;
  assign bus.HRDATA = hrdata_q;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: one instance with one wait state for single
// transfers, one with zero wait states for pipelined streams.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  logic HCLK = 1'b0;
  logic HRESTn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_slave_mem_if bus1 ();
  ahb_slave_mem_if bus0 ();

  ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(1)) u_dut (
    .HCLK(HCLK), .HRESTn(HRESTn), .bus(bus1));
  ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESTn(HRESTn), .bus(bus0));

  int checks = 0;
  int failures = 0;
  logic [7:0]  m1 [256];
  logic [7:0]  m0 [256];
  logic [31:0] last_exp = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference memory: plain byte array, addresses wrap at 256.
  function automatic logic [31:0] mread(input bit sel0, input logic [31:0] addr, input logic [2:0] size);
    int a;
    logic [7:0] b [4];
    a = int'(addr % 256);
    if (size != 3'b000) a = a - (a % 4);
    for (int k = 0; k < 4; k++) b[k] = sel0 ? m0[(a + k) % 256] : m1[(a + k) % 256];
    if (size == 3'b000) return {24'h0, b[0]};
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic mwrite(input bit sel0, input logic [31:0] addr, input logic [2:0] size, input logic [31:0] d);
    int a;
    a = int'(addr % 256);
    if (size == 3'b000) begin
      if (sel0) m0[a] = d[7:0]; else m1[a] = d[7:0];
    end else begin
      a = a - (a % 4);
      for (int k = 0; k < 4; k++)
        if (sel0) m0[a + k] = d[8*k +: 8]; else m1[a + k] = d[8*k +: 8];
    end
  endtask

  // One transfer on the wait-state instance; called at posedge+1 with bus idle.
  task automatic xfer1(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic resp_first, output logic resp_last, output int cyc);
    bus1.HSEL = 1'b1; bus1.HTRANS = HTRANS_NONSEQ; bus1.HADDR = addr;
    bus1.HWRITE = wr; bus1.HSIZE = size; bus1.HBURST = hburst_e'($urandom_range(0, 1));
    @(posedge HCLK); #1;
    bus1.HSEL = 1'b0; bus1.HTRANS = HTRANS_IDLE; bus1.HWDATA = wd;
    cyc = 0;
    resp_first = 1'b0;
    do begin
      @(negedge HCLK);
      cyc++;
      if (cyc == 1) resp_first = bus1.HRESP;
    end while (!bus1.HREADY && cyc < 40);
    if (!bus1.HREADY) chk("timeout_hready", 32'(bus1.HREADY), 32'h1);
    rd = bus1.HRDATA;
    resp_last = bus1.HRESP;
    @(posedge HCLK); #1;
  endtask

  task automatic wr1(input string tag, input logic [31:0] addr, input logic [2:0] size, input logic [31:0] d);
    logic [31:0] rd; logic rf, rl; int cyc;
    xfer1(1'b1, addr, size, d, rd, rf, rl, cyc);
    chk({tag, "_cycles"}, 32'(cyc), 32'd2);
    chk({tag, "_resp"}, 32'(rl), 32'h0);
    mwrite(1'b0, addr, size, d);
  endtask

  task automatic rd1(input string tag, input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] rd; logic rf, rl; int cyc;
    xfer1(1'b0, addr, size, 32'h0, rd, rf, rl, cyc);
    last_exp = mread(1'b0, addr, size);
    chk({tag, "_data"}, rd, last_exp);
    chk({tag, "_cycles"}, 32'(cyc), 32'd2);
    chk({tag, "_resp"}, 32'(rl), 32'h0);
  endtask

  localparam int N0 = 24;
  bit          opw [N0];
  logic [31:0] opa [N0];
  logic [2:0]  ops [N0];
  logic [31:0] opd [N0];
  logic [31:0] ope [N0];

  initial begin
    logic [31:0] rd; logic rf, rl; int cyc;
    bus1.HSEL = 0; bus1.HTRANS = HTRANS_IDLE; bus1.HADDR = 0; bus1.HWRITE = 0;
    bus1.HSIZE = 3'b010; bus1.HBURST = HBURST_SINGLE; bus1.HWDATA = 0;
    bus0.HSEL = 0; bus0.HTRANS = HTRANS_IDLE; bus0.HADDR = 0; bus0.HWRITE = 0;
    bus0.HSIZE = 3'b010; bus0.HBURST = HBURST_SINGLE; bus0.HWDATA = 0;

    // Reset state
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_hready", 32'(bus1.HREADY), 32'h1);
    chk("rst_hresp", 32'(bus1.HRESP), 32'h0);
    chk("rst_hrdata", bus1.HRDATA, 32'h0);
    chk("rst_hready0", 32'(bus0.HREADY), 32'h1);
    @(posedge HCLK); #1;
    HRESTn = 1'b1;
    @(posedge HCLK); #1;

    // Word write then read back, two-cycle data phase each
    wr1("w10", 32'h10, 3'b010, 32'hDEADBEEF);
    rd1("r10", 32'h10, 3'b010);
    chk("r10_const", last_exp, 32'hDEADBEEF);

    // Fill whole memory so every later read has a known reference
    for (int a = 0; a < 256; a += 4) wr1("fill", 32'(a), 3'b010, $urandom);

    // Byte lanes and little-endian assembly
    wr1("b0", 32'h0, 3'b000, 32'h11);
    wr1("b1", 32'h1, 3'b000, 32'h22);
    wr1("b2", 32'h2, 3'b000, 32'h33);
    wr1("b3", 32'h3, 3'b000, 32'h44);
    rd1("rw0", 32'h0, 3'b010);
    chk("rw0_const", last_exp, 32'h44332211);
    rd1("rb2", 32'h2, 3'b000);
    chk("rb2_const", last_exp, 32'h00000033);

    // Randomized single transfers
    for (int k = 0; k < 60; k++) begin
      bit w, b;
      logic [31:0] a;
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      a = b ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 63) * 4);
      if (w) wr1("rnd_w", a, b ? 3'b000 : 3'b010, $urandom);
      else   rd1("rnd_r", a, b ? 3'b000 : 3'b010);
    end

    // BUSY with HSEL: zero-wait OKAY, no access, HRDATA held
    bus1.HSEL = 1; bus1.HTRANS = HTRANS_BUSY; bus1.HWRITE = 1;
    bus1.HADDR = 32'h0; bus1.HSIZE = 3'b010;
    @(posedge HCLK); #1;
    bus1.HWDATA = 32'hBAD0BAD0;
    @(negedge HCLK);
    chk("busy_hready", 32'(bus1.HREADY), 32'h1);
    chk("busy_hresp", 32'(bus1.HRESP), 32'h0);
    chk("busy_hold", bus1.HRDATA, last_exp);
    @(posedge HCLK); #1;
    bus1.HSEL = 0; bus1.HTRANS = HTRANS_IDLE; bus1.HWRITE = 0;
    rd1("busy_mem", 32'h0, 3'b010);

`ifdef SLAVE_ERR_EN
    xfer1(1'b0, 32'h101, 3'b010, 32'h0, rd, rf, rl, cyc);
    chk("err_oor_first", 32'(rf), 32'h1);
    chk("err_oor_last", 32'(rl), 32'h1);
    chk("err_oor_cycles", 32'(cyc), 32'd2);
    xfer1(1'b1, 32'h12, 3'b010, 32'h5A5A5A5A, rd, rf, rl, cyc);
    chk("err_mis_last", 32'(rl), 32'h1);
    xfer1(1'b1, 32'h10, 3'b001, 32'hA5A5A5A5, rd, rf, rl, cyc);
    chk("err_size_last", 32'(rl), 32'h1);
    rd1("err_unchanged", 32'h10, 3'b010);
`else
    wr1("wrap_w", 32'h105, 3'b000, 32'h55);
    rd1("wrap_r", 32'h05, 3'b000);
    chk("wrap_const", last_exp, 32'h55);
    rd1("mis_r", 32'h13, 3'b010);
    wr1("sz1_w", 32'h20, 3'b001, 32'h01234567);
    rd1("sz1_r", 32'h20, 3'b010);
    chk("sz1_const", last_exp, 32'h01234567);
`endif

    // Reset during WAIT of a write: write dropped
    bus1.HSEL = 1; bus1.HTRANS = HTRANS_NONSEQ; bus1.HADDR = 32'h20;
    bus1.HWRITE = 1; bus1.HSIZE = 3'b010;
    @(posedge HCLK); #1;
    bus1.HSEL = 0; bus1.HTRANS = HTRANS_IDLE; bus1.HWRITE = 0; bus1.HWDATA = 32'hCAFEF00D;
    @(negedge HCLK);
    chk("wait_hready", 32'(bus1.HREADY), 32'h0);
    HRESTn = 1'b0;
    #1;
    chk("arst_hready", 32'(bus1.HREADY), 32'h1);
    chk("arst_hresp", 32'(bus1.HRESP), 32'h0);
    chk("arst_hrdata", bus1.HRDATA, 32'h0);
    repeat (2) @(posedge HCLK);
    #1 HRESTn = 1'b1;
    @(posedge HCLK); #1;
    rd1("arst_old", 32'h20, 3'b010);

    // Pipelined stream on zero-wait instance
    for (int i = 0; i < N0; i++) begin
      if (i < 8) begin
        opw[i] = 1; opa[i] = 32'(i * 4); ops[i] = 3'b010;
      end else if (i == 8) begin
        opw[i] = 1; opa[i] = 32'h05; ops[i] = 3'b000;
      end else if (i == 9) begin
        opw[i] = 0; opa[i] = 32'h04; ops[i] = 3'b010;
      end else begin
        bit b;
        b = 1'($urandom_range(0, 1));
        opw[i] = 1'($urandom_range(0, 1));
        opa[i] = b ? 32'($urandom_range(0, 31)) : 32'($urandom_range(0, 7) * 4);
        ops[i] = b ? 3'b000 : 3'b010;
      end
      opd[i] = $urandom;
      if (opw[i]) mwrite(1'b1, opa[i], ops[i], opd[i]);
      else ope[i] = mread(1'b1, opa[i], ops[i]);
    end
    for (int i = 0; i <= N0; i++) begin
      if (i > 0 && opw[i-1]) bus0.HWDATA = opd[i-1];
      if (i < N0) begin
        bus0.HSEL = 1; bus0.HTRANS = (i % 3 == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        bus0.HADDR = opa[i]; bus0.HWRITE = opw[i]; bus0.HSIZE = ops[i];
        bus0.HBURST = HBURST_INCR;
      end else begin
        bus0.HSEL = 0; bus0.HTRANS = HTRANS_IDLE; bus0.HWRITE = 0;
      end
      @(negedge HCLK);
      chk("pipe_hready", 32'(bus0.HREADY), 32'h1);
      chk("pipe_hresp", 32'(bus0.HRESP), 32'h0);
      if (i > 0 && !opw[i-1]) chk("pipe_data", bus0.HRDATA, ope[i-1]);
      @(posedge HCLK); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning memory size in bytes (power of two, >= 4).
REQ-002 SHALL have parameter WAIT_STATES, default 1, meaning data-phase wait cycles inserted per transfer (0..15).
REQ-003 SHALL have port HCLK  input  1  system clock, rising edge.
REQ-004 SHALL have port HRESTn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port HSEL  input  1  slave select.
REQ-006 SHALL have port HADDR  input  32  byte address.
REQ-007 SHALL have port HWRITE  input  1  1 = write, 0 = read.
REQ-008 SHALL have port HSIZE  input  3  000 = byte, 010 = word; other values are errors.
REQ-009 SHALL have port HTRANS  input  2  IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
REQ-010 SHALL have port HBURST  input  1  0 = single, 1 = INCR; informational only.
REQ-011 SHALL have port HWDATA  input  32  write data, valid in the data phase.
REQ-012 SHALL have port HRDATA  output  32  read data.
REQ-013 SHALL have port HREADY  output  1  transfer-complete / address-accept.
REQ-014 SHALL have port HRESP  output  1  0 = OKAY, 1 = ERROR.

Function
REQ-015 SHALL accept an address phase in any cycle where HREADY=1, HSEL=1 and HTRANS[1]=1, registering HADDR, HWRITE and HSIZE.
REQ-016 SHALL treat SEQ identically to NONSEQ and SHALL ignore HBURST.
REQ-017 SHALL answer IDLE, BUSY or unselected cycles with a zero-wait OKAY (HREADY=1, HRESP=0) and no memory access.
REQ-018 SHALL implement FSM states IDLE, WAIT, DONE, ERR1 and ERR2.
- IDLE -> WAIT on accept when WAIT_STATES > 0.
- IDLE -> DONE on accept when WAIT_STATES = 0.
- WAIT -> DONE after WAIT_STATES cycles.
- DONE -> WAIT, DONE or IDLE according to whether a new transfer is accepted.
REQ-019 SHALL drive HREADY=0 in WAIT and HREADY=1 in DONE; latency from accept to completion is WAIT_STATES+1 cycles.
REQ-020 SHALL, for a byte read, return mem[addr] zero-extended on HRDATA[7:0]; this lane placement is fixed team-wide.
REQ-021 SHALL, for a word read, return {mem[a+3], mem[a+2], mem[a+1], mem[a]} (little-endian, a = addr with bits [1:0] cleared).
REQ-022 SHALL present HRDATA during the cycle in which HREADY=1 completes the read, and hold the last value at all other times.
REQ-023 SHALL sample HWDATA on the completing cycle of a write.
- Byte write: stores HWDATA[7:0].
- Word write: stores all four bytes little-endian.
REQ-024 SHALL accept a new address phase in the same cycle a data phase completes (pipelined back-to-back).
REQ-025 SHALL wrap addresses modulo DEPTH when SLAVE_ERR_EN is undefined.
REQ-026 SHALL make a read of a byte written on the immediately preceding transfer return the new value.

Reset
REQ-027 SHALL, while HRESTn=0, force state IDLE, HREADY=1, HRESP=0 and HRDATA=0, and clear the wait counter.
REQ-028 SHALL discard any in-flight transfer on reset assertion; a pending write SHALL NOT modify memory.
REQ-029 SHALL NOT reset memory contents.

Configuration
REQ-030 SHALL, with SLAVE_ERR_EN defined, flag an error for any of:
- HADDR >= DEPTH;
- a word access with HADDR[1:0] != 0;
- HSIZE not 000 or 010.
REQ-031 SHALL, for a flagged transfer, give the two-cycle AHB ERROR response: ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1), with no memory access and no wait states.
REQ-032 SHALL, without SLAVE_ERR_EN, never assert HRESP.
- Addresses wrap.
- Misaligned words align down.
- Unsupported HSIZE is treated as word.

Structure
REQ-033 SHALL take the HTRANS, HSIZE, HBURST and slave-state enums from shared package ahb_pkg, which the team's AHB master also uses.
REQ-034 SHALL instantiate sub-module ahb_byte_ram (DEPTH x 8, one write port with 4-byte enable, one 4-byte read port) for storage.

Verification
REQ-035 SHALL cover: reset, then word write 0xDEADBEEF to 0x10 and word read of 0x10 -> HRDATA=0xDEADBEEF, HRESP=0, each transfer taking 2 cycles with WAIT_STATES=1.
REQ-036 SHALL cover: byte writes 0x11, 0x22, 0x33, 0x44 to 0x00..0x03, then word read of 0x00 -> 0x44332211, and byte read of 0x02 -> 0x00000033.
REQ-037 SHALL cover: back-to-back NONSEQ reads with WAIT_STATES=0 -> HREADY constantly 1, one result per cycle.
REQ-038 SHALL cover: with SLAVE_ERR_EN, a word read at 0x101 (DEPTH=256) -> HREADY 0 then 1 with HRESP=1 on both cycles, and memory unchanged.
REQ-039 SHALL cover: HRESTn dropped during WAIT of a write to 0x20 -> HREADY=1 immediately, and a later read of 0x20 returns the old data.
REQ-040 SHALL cover: HTRANS=BUSY with HSEL=1 -> HREADY=1, HRESP=0, and no access.
